// File: rtl/shmem_port_arbiter.sv
// Round-robin owner arbiter for the shared-memory port: one processor holds the port
// for a full fetch/fetch/write transaction while its address, data and size are muxed out.
module shmem_port_arbiter #(
  parameter int N_PROC = 4,
  parameter int ADDR_W = 16,
  parameter int BUS_W  = 80,
  parameter int SIZE_W = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_PROC-1:0]          i_req_rd,
  input  logic [N_PROC-1:0]          i_req_wr,
  input  logic [N_PROC-1:0]          i_wr_en,
  input  logic [N_PROC*ADDR_W-1:0]   i_addr,
  input  logic [N_PROC*BUS_W-1:0]    i_wdata,
  input  logic [N_PROC*SIZE_W-1:0]   i_wr_size,
  output logic [N_PROC-1:0]          o_grant_rd,
  output logic [N_PROC-1:0]          o_grant_wr,
  output logic [BUS_W-1:0]           o_rdata,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic                       o_mem_rd_en,
  output logic                       o_mem_wr_en,
  output logic [BUS_W-1:0]           o_mem_wdata,
  output logic [SIZE_W-1:0]          o_mem_wr_size,
  input  logic [BUS_W-1:0]           i_mem_rdata,
  output logic [$clog2(N_PROC)-1:0]  o_owner,
  output logic                       o_busy
);

  // state | meaning
  // IDLE  | no owner; port outputs held at zero
  // OWN   | owner_q holds the port until its write is granted or it stops requesting
  localparam int PW = $clog2(N_PROC);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [N_PROC-1:0] act;
  logic [N_PROC-1:0] act_masked;
  logic [PW-1:0]     owner_inc;
  logic [PW:0]       pick_idle;
  logic [PW:0]       pick_rel;
  logic              own_rd;
  logic              own_wr;
  logic              own_act;
  logic              own_grant_wr;
  logic              release_own;

  // Returns {found, index} of the first set bit scanning from ptr upward with wrap.
  function automatic logic [PW:0] rr_pick(input logic [N_PROC-1:0] req,
                                          input logic [PW-1:0]     ptr);
    logic          found;
    logic [PW-1:0] idx;
    int            k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_PROC; i++) begin
      k = (int'(ptr) + i) % N_PROC;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = PW'(k);
      end
    end
    return {found, idx};
  endfunction

  assign act          = i_req_rd | i_req_wr;
  assign own_rd       = i_req_rd[owner_q];
  assign own_wr       = i_req_wr[owner_q];
  assign own_act      = act[owner_q];
  assign own_grant_wr = own_wr & ~own_rd;
  assign release_own  = own_grant_wr | ~own_act;
  assign owner_inc    = (owner_q == PW'(N_PROC - 1)) ? '0 : owner_q + 1'b1;
  assign act_masked   = act & ~(N_PROC'(1) << owner_q);
  assign pick_idle    = rr_pick(act, rr_ptr_q);
  assign pick_rel     = rr_pick(act_masked, owner_inc);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[PW]) begin
          state_d = OWN;
          owner_d = pick_idle[PW-1:0];
        end
      end
      OWN: begin
        if (release_own) begin
          rr_ptr_d = owner_inc;
          // Hand straight to the next requester so back-to-back tenures have no bubble.
          if (pick_rel[PW]) begin
            owner_d = pick_rel[PW-1:0];
          end else begin
            state_d = IDLE;
            owner_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_comb begin
    o_grant_rd    = '0;
    o_grant_wr    = '0;
    o_mem_addr    = '0;
    o_mem_rd_en   = 1'b0;
    o_mem_wr_en   = 1'b0;
    o_mem_wdata   = '0;
    o_mem_wr_size = '0;
    o_owner       = '0;
    o_busy        = 1'b0;
    if (state_q == OWN) begin
      o_grant_rd[owner_q] = own_rd;
      o_grant_wr[owner_q] = own_grant_wr;
      o_mem_addr          = i_addr[owner_q*ADDR_W +: ADDR_W];
      o_mem_wdata         = i_wdata[owner_q*BUS_W +: BUS_W];
      o_mem_wr_size       = i_wr_size[owner_q*SIZE_W +: SIZE_W];
      o_mem_rd_en         = own_rd;
      // A simultaneous read wins, so the write strobe only passes with the write grant.
      o_mem_wr_en         = own_grant_wr & i_wr_en[owner_q];
      o_owner             = owner_q;
      o_busy              = 1'b1;
    end
  end

  assign o_rdata = i_mem_rdata;

endmodule

// File: tb/tb_shmem_port_arbiter.sv
// Scoreboard bench for shmem_port_arbiter: a driver predicts each cycle's port outputs
// from an abstract ownership model and a monitor compares them against the DUT.
module tb_shmem_port_arbiter;
  localparam int N      = 4;
  localparam int ADDR_W = 16;
  localparam int BUS_W  = 80;
  localparam int SIZE_W = 3;

  logic                  clk;
  logic                  i_rst;
  logic [N-1:0]          i_req_rd, i_req_wr, i_wr_en;
  logic [N*ADDR_W-1:0]   i_addr;
  logic [N*BUS_W-1:0]    i_wdata;
  logic [N*SIZE_W-1:0]   i_wr_size;
  logic [N-1:0]          o_grant_rd, o_grant_wr;
  logic [BUS_W-1:0]      o_rdata, o_mem_wdata, i_mem_rdata;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic                  o_mem_rd_en, o_mem_wr_en, o_busy;
  logic [SIZE_W-1:0]     o_mem_wr_size;
  logic [1:0]            o_owner;

  shmem_port_arbiter #(.N_PROC(N), .ADDR_W(ADDR_W), .BUS_W(BUS_W), .SIZE_W(SIZE_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_rd(i_req_rd), .i_req_wr(i_req_wr), .i_wr_en(i_wr_en),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wr_size(i_wr_size),
    .o_grant_rd(o_grant_rd), .o_grant_wr(o_grant_wr), .o_rdata(o_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_wdata(o_mem_wdata), .o_mem_wr_size(o_mem_wr_size), .i_mem_rdata(i_mem_rdata),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]      grant_rd;
    logic [N-1:0]      grant_wr;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              wr_en;
    logic [BUS_W-1:0]  wdata;
    logic [SIZE_W-1:0] size;
    logic [1:0]        owner;
    logic              busy;
    logic [BUS_W-1:0]  rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Abstract ownership model: who holds the port and who is next in line.
  bit m_busy = 0;
  int m_owner = 0;
  int m_ptr = 0;

  function automatic int first_from(input logic [N-1:0] req, input int start);
    for (int i = 0; i < N; i++)
      if (req[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] rd, input logic [N-1:0] wr,
                      input logic [N-1:0] wen, input logic [N*ADDR_W-1:0] addr);
    exp_t e;
    logic [N-1:0] act;
    bit rel;
    int w;
    @(negedge clk);
    i_rst = rst; i_req_rd = rd; i_req_wr = wr; i_wr_en = wen; i_addr = addr;
    for (int p = 0; p < N; p++) begin
      i_wdata[p*BUS_W +: BUS_W] = {16'($urandom), $urandom, $urandom};
      i_wr_size[p*SIZE_W +: SIZE_W] = SIZE_W'($urandom_range(0, 5));
    end
    i_mem_rdata = {16'($urandom), $urandom, $urandom};
    #2;
    e = '{default: '0};
    e.rdata = i_mem_rdata;
    act = rd | wr;
    if (!rst && m_busy) begin
      e.busy  = 1'b1;
      e.owner = 2'(m_owner);
      e.addr  = addr[m_owner*ADDR_W +: ADDR_W];
      e.wdata = i_wdata[m_owner*BUS_W +: BUS_W];
      e.size  = i_wr_size[m_owner*SIZE_W +: SIZE_W];
      e.rd_en = rd[m_owner];
      if (rd[m_owner]) e.grant_rd[m_owner] = 1'b1;
      if (wr[m_owner] && !rd[m_owner]) begin
        e.grant_wr[m_owner] = 1'b1;
        e.wr_en = wen[m_owner];
      end
    end
    exp_q.push_back(e);
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0;
    end else if (!m_busy) begin
      w = first_from(act, m_ptr);
      if (w >= 0) begin m_busy = 1; m_owner = w; end
    end else begin
      rel = (wr[m_owner] && !rd[m_owner]) || !act[m_owner];
      if (rel) begin
        m_ptr = (m_owner + 1) % N;
        act[m_owner] = 1'b0;
        w = first_from(act, m_ptr);
        if (w >= 0) m_owner = w;
        else begin m_busy = 0; m_owner = 0; end
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_rd", BUS_W'(o_grant_rd), BUS_W'(e.grant_rd));
        chk("grant_wr", BUS_W'(o_grant_wr), BUS_W'(e.grant_wr));
        chk("mem_addr", BUS_W'(o_mem_addr), BUS_W'(e.addr));
        chk("mem_rd_en", BUS_W'(o_mem_rd_en), BUS_W'(e.rd_en));
        chk("mem_wr_en", BUS_W'(o_mem_wr_en), BUS_W'(e.wr_en));
        chk("mem_wdata", o_mem_wdata, e.wdata);
        chk("mem_wr_size", BUS_W'(o_mem_wr_size), BUS_W'(e.size));
        chk("owner", BUS_W'(o_owner), BUS_W'(e.owner));
        chk("busy", BUS_W'(o_busy), BUS_W'(e.busy));
        chk("rdata", o_rdata, e.rdata);
      end
    end
  end

  function automatic logic [N*ADDR_W-1:0] addr_all(input logic [ADDR_W-1:0] a);
    logic [N*ADDR_W-1:0] v;
    for (int p = 0; p < N; p++) v[p*ADDR_W +: ADDR_W] = a + ADDR_W'(p);
    return v;
  endfunction

  function automatic logic [N*ADDR_W-1:0] addr_rand();
    logic [N*ADDR_W-1:0] v;
    for (int p = 0; p < N; p++) v[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    return v;
  endfunction

  initial begin
    i_rst = 1'b1; i_req_rd = '0; i_req_wr = '0; i_wr_en = '0;
    i_addr = '0; i_wdata = '0; i_wr_size = '0; i_mem_rdata = '0;
    step(1, 4'b0000, 4'b0000, 4'b0000, '0);
    step(0, 4'b0000, 4'b0000, 4'b0000, '0);

    // Proc0 alone: two fetches then a write; addresses 0x10, 0x20, 0x30.
    step(0, 4'b0001, 4'b0000, 4'b0000, addr_all(16'h0010));
    step(0, 4'b0001, 4'b0000, 4'b0000, addr_all(16'h0020));
    step(0, 4'b0000, 4'b0001, 4'b0001, addr_all(16'h0030));
    step(0, 4'b0000, 4'b0000, 4'b0000, addr_all(16'h0000));

    // Procs 1 and 2 together after reset: proc1 first, proc2 follows with no gap.
    step(1, 4'b0000, 4'b0000, 4'b0000, '0);
    step(0, 4'b0110, 4'b0000, 4'b0000, addr_rand());
    step(0, 4'b0110, 4'b0000, 4'b0000, addr_rand());
    step(0, 4'b0100, 4'b0010, 4'b0010, addr_rand());
    step(0, 4'b0100, 4'b0000, 4'b0000, addr_rand());
    step(0, 4'b0000, 4'b0100, 4'b0100, addr_rand());
    step(0, 4'b0000, 4'b0000, 4'b0000, addr_rand());

    // All four writing continuously: owner rotates 0,1,2,3,0.
    step(1, 4'b0000, 4'b0000, 4'b0000, '0);
    for (int i = 0; i < 7; i++) step(0, 4'b0000, 4'b1111, 4'b1111, addr_rand());
    step(0, 4'b0000, 4'b0000, 4'b0000, addr_rand());

    // Proc3 owns then abandons without writing.
    step(1, 4'b0000, 4'b0000, 4'b0000, '0);
    step(0, 4'b1000, 4'b0000, 4'b0000, addr_rand());
    step(0, 4'b1000, 4'b0000, 4'b0000, addr_rand());
    step(0, 4'b0000, 4'b0000, 4'b0000, addr_rand());
    step(0, 4'b0000, 4'b0000, 4'b0000, addr_rand());

    // Reset lands during proc0's write cycle.
    step(0, 4'b0001, 4'b0000, 4'b0000, addr_rand());
    step(0, 4'b0001, 4'b0000, 4'b0000, addr_rand());
    step(1, 4'b0000, 4'b0001, 4'b0001, addr_rand());
    step(0, 4'b0000, 4'b0000, 4'b0000, addr_rand());

    // Owner asserts read and write together: read wins, tenure held.
    step(0, 4'b0100, 4'b0000, 4'b0000, addr_rand());
    step(0, 4'b0100, 4'b0100, 4'b0100, addr_rand());
    step(0, 4'b0100, 4'b0100, 4'b0100, addr_rand());
    step(0, 4'b0000, 4'b0100, 4'b0100, addr_rand());
    step(0, 4'b0000, 4'b0000, 4'b0000, addr_rand());

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] rd, wr, wen;
      for (int p = 0; p < N; p++) begin
        rd[p]  = ($urandom_range(0, 9) < 5);
        wr[p]  = ($urandom_range(0, 9) < 3);
        wen[p] = ($urandom_range(0, 9) < 7);
      end
      step(($urandom_range(0, 99) == 0), rd, wr, wen, addr_rand());
    end

    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
